// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-input round-robin packet arbiter.
// Holds the requester count, select width, FSM state type and the
// rotating-priority search used in IDLE.
package mux4_arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Rotating-priority search: ptr has the highest priority, then ptr+1, and so on.
    // The loop runs from the lowest priority up, so the last hit written is the winner.
    function automatic pick_t rr_pick(input logic [NREQ-1:0]  valid,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4_word.sv
// Combinational WIDTH-bit 4:1 word mux; word i sits at data[i*WIDTH +: WIDTH].
module mux4_word
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [NREQ*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      y
);

    // Select one requester word.
    always_comb begin
        y = '0;
        unique case (sel)
            2'd0: y = data[0*WIDTH +: WIDTH];
            2'd1: y = data[1*WIDTH +: WIDTH];
            2'd2: y = data[2*WIDTH +: WIDTH];
            2'd3: y = data[3*WIDTH +: WIDTH];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready/last channel between 4 requesters.
// A grant is held for a whole packet; the beat path is a combinational
// pass-through of the granted requester.
// Optional build macro MUX4_RR_ARBITER_STATS_EN adds per-requester
// saturating win counters on port grant_cnt.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant held; outputs quiet; winner of rr_pick registered
// BUSY  | grant_sel owns the channel until its last beat is accepted
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      grant_sel,
`ifdef MUX4_RR_ARBITER_STATS_EN
    output logic [NREQ*16-1:0]    grant_cnt,
`endif
    output logic                  busy
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    pick_t            pick;
    logic [WIDTH-1:0] mux_y;
    logic             xfer;

    assign pick = rr_pick(req_valid, ptr);
    assign xfer = out_valid & out_ready;

    mux4_word #(.WIDTH(WIDTH)) u_data_mux (
        .data (req_data),
        .sel  (grant_sel),
        .y    (mux_y)
    );

    // Granted requester passes straight through while BUSY; everything is quiet in IDLE.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        req_ready = '0;
        busy      = (state == BUSY);
        if (state == BUSY) begin
            out_valid            = req_valid[grant_sel];
            out_last             = req_last[grant_sel];
            out_data             = mux_y;
            req_ready[grant_sel] = out_ready;
        end
    end

    // Arbitration FSM: latch a winner in IDLE, release after the last beat transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_sel <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick.found) begin
                        grant_sel <= pick.idx;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Priority rotates to the requester after the one just served; 2-bit wrap.
                    if (xfer && out_last) begin
                        ptr   <= grant_sel + SEL_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUX4_RR_ARBITER_STATS_EN
    // Count arbitration wins per requester, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (state == IDLE && pick.found) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pick.idx == SEL_W'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (WIDTH=8).
// Inputs change 1 time unit after a rising edge; outputs are checked on the falling edge.
module tb_mux4_rr_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req_valid;
    logic [4*W-1:0] req_data;
    logic [3:0]     req_last;
    logic [3:0]     req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [1:0]     grant_sel;
    logic           busy;
`ifdef MUX4_RR_ARBITER_STATS_EN
    logic [63:0]    grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] xlog[$];

    mux4_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_sel (grant_sel),
`ifdef MUX4_RR_ARBITER_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every accepted downstream beat.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) xlog.push_back(out_data);
    end

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, busy, req_ready, grant_sel, out_data} !== {1'b0, 1'b0, 4'b0000, 2'd0, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got v=%b busy=%b rdy=%b sel=%0d data=%h, expected all zero",
                         i, out_valid, busy, req_ready, grant_sel, out_data);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]   exp_sel;
        logic [W-1:0] exp_d;
        for (int k = 0; k < 4; k++) req_data[k*W +: W] = 8'hA0 + 8'(k);
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_sel = 2'(k % 4);
            exp_d   = 8'hA0 + 8'(k % 4);
            tick();
            @(negedge clk);
            n_checks++;
            if ({busy, out_valid, out_last, grant_sel, out_data, req_ready} !==
                {1'b1, 1'b1, 1'b1, exp_sel, exp_d, 4'b0001 << exp_sel}) begin
                n_fail++;
                $display("FAIL rr_grant %0d: got busy=%b v=%b l=%b sel=%0d data=%h rdy=%b, expected sel=%0d data=%h",
                         k, busy, out_valid, out_last, grant_sel, out_data, req_ready, exp_sel, exp_d);
            end
            tick();
            @(negedge clk);
            n_checks++;
            if ({busy, out_valid, req_ready} !== {1'b0, 1'b0, 4'b0000}) begin
                n_fail++;
                $display("FAIL rr_bubble %0d: got busy=%b v=%b rdy=%b, expected 0 0 0000",
                         k, busy, out_valid, req_ready);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_packet();
        // ptr is 1: a single beat from req 1 moves it to 2.
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_data[1*W +: W] = 8'h55;
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant_sel, out_data} !== {2'd1, 8'h55}) begin
            n_fail++;
            $display("FAIL pkt_prep: got sel=%0d data=%h, expected 1 55", grant_sel, out_data);
        end
        tick();
        // Now IDLE with ptr=2; req 2 wins over req 1.
        req_valid = 4'b0110;
        req_last  = 4'b0010;
        req_data[2*W +: W] = 8'h11;
        req_data[1*W +: W] = 8'h77;
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant_sel, out_data, out_last, req_ready} !== {2'd2, 8'h11, 1'b0, 4'b0100}) begin
            n_fail++;
            $display("FAIL pkt_beat1: got sel=%0d data=%h last=%b rdy=%b, expected 2 11 0 0100",
                     grant_sel, out_data, out_last, req_ready);
        end
        tick();
        req_data[2*W +: W] = 8'h22;
        @(negedge clk);
        n_checks++;
        if ({busy, grant_sel, out_data, out_last} !== {1'b1, 2'd2, 8'h22, 1'b0}) begin
            n_fail++;
            $display("FAIL pkt_beat2: got busy=%b sel=%0d data=%h last=%b, expected 1 2 22 0",
                     busy, grant_sel, out_data, out_last);
        end
        tick();
        req_data[2*W +: W] = 8'h33;
        req_last = 4'b0110;
        @(negedge clk);
        n_checks++;
        if ({busy, grant_sel, out_data, out_last} !== {1'b1, 2'd2, 8'h33, 1'b1}) begin
            n_fail++;
            $display("FAIL pkt_beat3: got busy=%b sel=%0d data=%h last=%b, expected 1 2 33 1",
                     busy, grant_sel, out_data, out_last);
        end
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        n_checks++;
        if ({busy, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL pkt_bubble: got busy=%b v=%b, expected 0 0", busy, out_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant_sel, out_data, out_valid} !== {2'd1, 8'h77, 1'b1}) begin
            n_fail++;
            $display("FAIL pkt_next_grant: got sel=%0d data=%h v=%b, expected 1 77 1",
                     grant_sel, out_data, out_valid);
        end
        tick();
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_stall();
        // ptr is 2.
        xlog.delete();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data[2*W +: W] = 8'hB1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_data, out_valid, req_ready, grant_sel} !== {8'hB1, 1'b1, 4'b0000, 2'd2}) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got data=%h v=%b rdy=%b sel=%0d, expected B1 1 0000 2",
                         i, out_data, out_valid, req_ready, grant_sel);
            end
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b, expected 0100", req_ready);
        end
        tick();
        req_data[2*W +: W] = 8'hB2;
        tick();
        req_data[2*W +: W] = 8'hB3;
        req_last = 4'b0100;
        tick();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end_idle: got busy=%b, expected 0", busy);
        end
        n_checks++;
        if (xlog.size() != 3) begin
            n_fail++;
            $display("FAIL stall_beat_count: got %0d beats, expected 3", xlog.size());
        end else begin
            n_checks++;
            if ({xlog[0], xlog[1], xlog[2]} !== {8'hB1, 8'hB2, 8'hB3}) begin
                n_fail++;
                $display("FAIL stall_beat_data: got %h %h %h, expected B1 B2 B3", xlog[0], xlog[1], xlog[2]);
            end
        end
        tick();
    endtask

    task automatic test_drop();
        // ptr is 3; req 0 alone first, then req 3 competes mid-packet.
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        req_data[0*W +: W] = 8'hC1;
        req_data[3*W +: W] = 8'hD3;
        out_ready = 1'b1;
        tick();
        req_valid = 4'b1001;
        req_last  = 4'b1000;
        @(negedge clk);
        n_checks++;
        if ({grant_sel, out_data, req_ready} !== {2'd0, 8'hC1, 4'b0001}) begin
            n_fail++;
            $display("FAIL drop_beat1: got sel=%0d data=%h rdy=%b, expected 0 C1 0001",
                     grant_sel, out_data, req_ready);
        end
        tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, grant_sel, busy} !== {1'b0, 2'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL drop_hold %0d: got v=%b sel=%0d busy=%b, expected 0 0 1",
                         i, out_valid, grant_sel, busy);
            end
            tick();
        end
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        req_data[0*W +: W] = 8'hC2;
        @(negedge clk);
        n_checks++;
        if ({out_valid, grant_sel, out_data, out_last} !== {1'b1, 2'd0, 8'hC2, 1'b1}) begin
            n_fail++;
            $display("FAIL drop_resume: got v=%b sel=%0d data=%h last=%b, expected 1 0 C2 1",
                     out_valid, grant_sel, out_data, out_last);
        end
        tick();
        req_valid = 4'b1000;
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant_sel, out_data} !== {2'd3, 8'hD3}) begin
            n_fail++;
            $display("FAIL drop_then_req3: got sel=%0d data=%h, expected 3 D3", grant_sel, out_data);
        end
        tick();
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        // ptr is 0; one beat from req 1 moves it to 2.
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_data[1*W +: W] = 8'h61;
        out_ready = 1'b1;
        tick();
        tick();
        // Four-beat packet from req 3, reset during beat 2.
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        req_data[3*W +: W] = 8'hE1;
        tick();
        tick();
        req_data[3*W +: W] = 8'hE2;
        @(negedge clk);
        n_checks++;
        if ({busy, grant_sel, out_data} !== {1'b1, 2'd3, 8'hE2}) begin
            n_fail++;
            $display("FAIL rstmid_beat2: got busy=%b sel=%0d data=%h, expected 1 3 E2", busy, grant_sel, out_data);
        end
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b0101;
        req_last  = 4'b0101;
        req_data[0*W +: W] = 8'h90;
        req_data[2*W +: W] = 8'h92;
        @(negedge clk);
        n_checks++;
        if ({busy, req_ready, out_valid, grant_sel} !== {1'b0, 4'b0000, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL rstmid_idle: got busy=%b rdy=%b v=%b sel=%0d, expected 0 0000 0 0",
                     busy, req_ready, out_valid, grant_sel);
        end
`ifdef MUX4_RR_ARBITER_STATS_EN
        n_checks++;
        if (grant_cnt !== 64'd0) begin
            n_fail++;
            $display("FAIL rstmid_stats: got %h, expected 0", grant_cnt);
        end
`endif
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant_sel, out_data} !== {2'd0, 8'h90}) begin
            n_fail++;
            $display("FAIL rstmid_ptr: got sel=%0d data=%h, expected 0 90 (ptr cleared)", grant_sel, out_data);
        end
        tick();
        req_valid = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet();
        test_stall();
        test_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
